// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - 2-bit counter BHT with tagged BTB and wrapping mispredict counter
module branch_predictor_bht #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic [31:0] mispredict_cnt
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  logic [INDEX_BITS-1:0] if_idx, upd_idx;
  logic [TAG_BITS-1:0]   if_tag, upd_tag;
  logic                  if_hit, upd_hit;

  logic        entry_we;
  logic [1:0]  ctr_d;
  logic [31:0] target_d;

  // Byte offset bits never select an entry; branches are word aligned.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  assign if_idx  = if_pc[INDEX_BITS+1:2];
  assign if_tag  = if_pc[31:INDEX_BITS+2];
  assign upd_idx = upd_pc[INDEX_BITS+1:2];
  assign upd_tag = upd_pc[31:INDEX_BITS+2];

  assign mispredict_cnt = mispredict_cnt_q;

  // Zero-latency lookup from registered table; no bypass from a same-cycle update.
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = !rst && if_hit && ctr_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : 32'h0;
  end

  // Training decision for the entry addressed by the resolving branch.
  always_comb begin
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    entry_we = 1'b0;
    ctr_d    = ctr_q[upd_idx];
    target_d = target_q[upd_idx];
    if (upd_valid) begin
      if (upd_hit) begin
        entry_we = 1'b1;
        if (upd_taken) begin
          ctr_d    = (ctr_q[upd_idx] == CTR_STRONG_T) ? CTR_STRONG_T : ctr_q[upd_idx] + 2'd1;
          target_d = upd_target;
        end else begin
          ctr_d    = (ctr_q[upd_idx] == CTR_STRONG_NT) ? CTR_STRONG_NT : ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate (or steal an aliased entry) only on a taken branch.
        entry_we = 1'b1;
        ctr_d    = CTR_WEAK_T;
        target_d = upd_target;
      end
    end
  end

  // Mispredict count wraps naturally at 32 bits.
  always_comb begin
    mispredict_cnt_d = mispredict_cnt_q +
                       {31'd0, (upd_valid && (upd_taken != upd_pred_taken))};
  end

  // Table and counter state; reset overrides any same-cycle training.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WEAK_NT;
      end
      mispredict_cnt_q <= 32'h0;
    end else begin
      if (entry_we) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= target_d;
        ctr_q[upd_idx]    <= ctr_d;
      end
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

endmodule
